// File: rtl/pipe_pkg.sv
// Shared state encoding and counter width for the pipeline stage buffer.
package pipe_pkg;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    function automatic logic [1:0] occ_of(input pipe_state_e s);
        case (s)
            EMPTY:   return 2'd0;
            HALF:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Payload register with load and clear; clear (or reset) parks it at BUBBLE.
// One cycle from ld_i to q_o; clear wins over load.
module pipe_stage_reg #(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            q_q <= BUBBLE;
        end else if (ld_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer, 1-cycle accept-to-valid, strict FIFO, flush to BUBBLE.
// PIPE_STAGE_BUF_SKID_EN: two-entry skid with registered in_ready; otherwise one entry.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    pipe_state_e            state_q, state_d;
    logic                   accept, consume;
    logic                   main_ld, main_clr;
    logic [DATA_W-1:0]      main_d, main_q;
    logic [STALL_CNT_W-1:0] stall_q;

    assign out_valid = (state_q != EMPTY);
    assign consume   = out_valid && out_ready;
    assign accept    = in_valid && in_ready;

`ifdef PIPE_STAGE_BUF_SKID_EN
    logic              in_ready_q;
    logic              skid_ld, skid_clr, main_from_skid;
    logic [DATA_W-1:0] skid_q;

    assign in_ready = in_ready_q;
    assign main_d   = main_from_skid ? skid_q : in_data;
`else
    assign in_ready = !out_valid || out_ready;
    assign main_d   = in_data;
`endif

    // main is cleared whenever the stage empties so out_data reads BUBBLE.
    always_comb begin
        state_d  = state_q;
        main_ld  = 1'b0;
        main_clr = 1'b0;
`ifdef PIPE_STAGE_BUF_SKID_EN
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        main_from_skid = 1'b0;
`endif
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
`ifdef PIPE_STAGE_BUF_SKID_EN
            skid_clr = 1'b1;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = HALF;
                        main_ld = 1'b1;
                    end
                end
                HALF: begin
                    if (accept && consume) begin
                        main_ld = 1'b1;
`ifdef PIPE_STAGE_BUF_SKID_EN
                    end else if (accept) begin
                        state_d = FULL;
                        skid_ld = 1'b1;
`endif
                    end else if (consume) begin
                        state_d  = EMPTY;
                        main_clr = 1'b1;
                    end
                end
`ifdef PIPE_STAGE_BUF_SKID_EN
                FULL: begin
                    if (consume) begin
                        state_d        = HALF;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    pipe_stage_reg #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_main (
        .clk   (clk),
        .rst   (rst),
        .clr_i (main_clr),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (main_q)
    );

`ifdef PIPE_STAGE_BUF_SKID_EN
    // Registered ready keeps out_ready off the upstream timing path.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != FULL);
        end
    end

    pipe_stage_reg #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr_i (skid_clr),
        .ld_i  (skid_ld),
        .d_i   (in_data),
        .q_o   (skid_q)
    );
`endif

    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and seeded-random bench for pipe_stage_buf, either skid configuration.
module tb_pipe_stage_buf;

    localparam int                DATA_W = 64;
    localparam logic [DATA_W-1:0] BUBBLE = 64'hDEAD_0000_0000_BEEF;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0] in_data, out_data;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_stall;

    logic [63:0] sb_q[$];
    logic [63:0] sb_exp;
    logic [63:0] nxt;
    logic        rv, rr;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, BUBBLE);
        check("rst_occ", occupancy, 2'd0);
        check("rst_stall", stall_cnt, 16'd0);
        check("rst_in_ready", in_ready, 1'b1);

        // Single transfer into an empty stage.
        drive(1'b1, 64'h1234, 1'b1, 1'b0);
        check("t1_in_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("t1_out_valid", out_valid, 1'b1);
        check("t1_out_data", out_data, 64'h1234);
        check("t1_occ", occupancy, 2'd1);
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("t1_drained", out_valid, 1'b0);
        check("t1_bubble", out_data, BUBBLE);

        // Back-to-back stream 1..8 with downstream always ready.
        for (int i = 0; i <= 8; i++) begin
            drive(i < 8, 64'(i + 1), 1'b1, 1'b0);
            if (i < 8) check("stream_in_ready", in_ready, 1'b1);
            if (i > 0) begin
                check("stream_vld", out_valid, 1'b1);
                check("stream_dat", out_data, 64'(i));
            end
            tick();
        end
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("stream_end", out_valid, 1'b0);

`ifdef PIPE_STAGE_BUF_SKID_EN
        drive(1'b1, 64'hA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'hB, 1'b0, 1'b0);
        check("skid_ready_half", in_ready, 1'b1);
        tick();
        drive(1'b1, 64'hEE, 1'b0, 1'b0);
        check("skid_full_occ", occupancy, 2'd2);
        check("skid_full_ready", in_ready, 1'b0);
        check("skid_full_data", out_data, 64'hA);
        check("skid_stall1", stall_cnt, 16'd1);
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("skid_hold_occ", occupancy, 2'd2);
        check("skid_hold_data", out_data, 64'hA);
        check("skid_stall2", stall_cnt, 16'd2);
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("skid_rel_vld", out_valid, 1'b1);
        check("skid_rel_data", out_data, 64'hB);
        check("skid_rel_occ", occupancy, 2'd1);
        check("skid_rel_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("skid_empty", out_valid, 1'b0);
        check("skid_stall_keep", stall_cnt, 16'd2);

        // Flush a full stage while upstream offers 0xC and downstream is ready.
        drive(1'b1, 64'hA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'hB, 1'b0, 1'b0);
        tick();
        exp_stall = 3;
`else
        drive(1'b1, 64'hA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'hEE, 1'b0, 1'b0);
        check("one_stall_ready", in_ready, 1'b0);
        check("one_stall_data", out_data, 64'hA);
        check("one_stall_occ", occupancy, 2'd1);
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("one_stall_cnt", stall_cnt, 16'd1);
        check("one_hold_data", out_data, 64'hA);
        check("one_comb_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("one_empty", out_valid, 1'b0);

        drive(1'b1, 64'hA, 1'b0, 1'b0);
        tick();
        exp_stall = 1;
`endif
        drive(1'b1, 64'hC, 1'b1, 1'b1);
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("flush_vld", out_valid, 1'b0);
        check("flush_data", out_data, BUBBLE);
        check("flush_occ", occupancy, 2'd0);
        check("flush_ready", in_ready, 1'b1);
        check("flush_stall", stall_cnt, 64'(exp_stall));
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("flush_no_c", out_valid, 1'b0);

        // Reset beats flush and a live handshake.
        rst = 1'b1;
        drive(1'b1, 64'h77, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("rst2_vld", out_valid, 1'b0);
        check("rst2_stall", stall_cnt, 16'd0);

        // Saturating stall counter.
        drive(1'b1, 64'h5A, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        for (int k = 0; k < 65534; k++) tick();
        check("sat_fffe", stall_cnt, 16'hFFFE);
        for (int k = 0; k < 66; k++) tick();
        check("sat_ffff", stall_cnt, 16'hFFFF);
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("sat_flush_keep", stall_cnt, 16'hFFFF);
        check("sat_flush_vld", out_valid, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("sat_rst_clear", stall_cnt, 16'd0);

        // Seeded random traffic against a queue scoreboard, then drain.
        void'($urandom(32'd2024));
        nxt = 64'h100;
        for (int c = 0; c < 10004; c++) begin
            rv = (c < 10000) && ($urandom_range(99) < 60);
            rr = (c >= 10000) || ($urandom_range(99) < 60);
            drive(rv, nxt, rr, 1'b0);
            check("rnd_occ", occupancy, sb_q.size());
            check("rnd_vld", out_valid, sb_q.size() != 0);
            if (out_valid && out_ready && sb_q.size() != 0) begin
                sb_exp = sb_q.pop_front();
                check("rnd_order", out_data, sb_exp);
            end else if (!out_valid) begin
                check("rnd_bubble", out_data, BUBBLE);
            end
            if (rv && in_ready) begin
                sb_q.push_back(nxt);
                nxt = nxt + 64'd1;
            end
            tick();
        end
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("rnd_final_vld", out_valid, sb_q.size() != 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 64: width of the stage payload (control fields and operands concatenated).
REQ-002 Parameter BUBBLE, default all-zero DATA_W: payload presented when the stage is empty or flushed (NOP).
REQ-003 Port clk  input  1: sole clock, rising edge.
REQ-004 Port rst  input  1: reset; one clock; reset is synchronous and active-high.
REQ-005 Port flush  input  1: discard all held entries (branch, interrupt, hazard squash).
REQ-006 Port in_valid  input  1: upstream stage offers in_data.
REQ-007 Port in_ready  output  1: buffer accepts in_data this cycle.
REQ-008 Port in_data  input  DATA_W: upstream payload.
REQ-009 Port out_valid  output  1: out_data holds a live instruction.
REQ-010 Port out_ready  input  1: downstream stage consumes out_data this cycle (deasserted = stall).
REQ-011 Port out_data  output  DATA_W: payload to downstream stage.
REQ-012 Port occupancy  output  2: number of held entries, 0..2.
REQ-013 Port stall_cnt  output  16: count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Accept SHALL occur on a cycle with in_valid=1 and in_ready=1; consume on out_valid=1 and out_ready=1.
REQ-015 Latency SHALL be exactly 1 cycle from accept to out_valid for an empty buffer; order SHALL be strictly FIFO.
REQ-016 Out_data SHALL equal BUBBLE whenever out_valid=0.
REQ-017 With skid enabled, states SHALL be EMPTY (occ 0), HALF (occ 1), FULL (occ 2), with a main register driving out_data and a skid register.
REQ-018 EMPTY + accept -> HALF, main <= in_data; EMPTY without accept remains EMPTY.
REQ-019 HALF + accept + consume -> HALF, main <= in_data; HALF + accept only -> FULL, skid <= in_data; HALF + consume only -> EMPTY; neither -> hold.
REQ-020 FULL + consume -> HALF, main <= skid; FULL without consume -> hold, no data change.
REQ-021 With skid enabled, in_ready SHALL be a register output, 1 iff next state is not FULL; no combinational path from out_ready to in_ready.
REQ-022 Flush SHALL force EMPTY on the next edge, out_valid=0, both registers <= BUBBLE; an accept in the flush cycle is discarded; flush overrides every transition.
REQ-023 Stall_cnt SHALL increment by 1 per stall cycle, saturate at 0xFFFF, and be unaffected by flush.
REQ-024 Simultaneous accept and consume in FULL cannot occur (in_ready=0); in_valid without in_ready SHALL change nothing.

Reset
REQ-025 On rst: state EMPTY, out_valid=0, out_data=BUBBLE, occupancy=0, stall_cnt=0, in_ready=1 on the first cycle after reset.
REQ-026 Rst SHALL take priority over flush and any handshake; entries held mid-operation are lost.

Configuration
REQ-027 Macro PIPE_STAGE_BUF_SKID_EN defined: two-entry skid behaviour of REQ-017..REQ-021, occupancy max 2.
REQ-028 Macro undefined: single register, states EMPTY/HALF only, in_ready = !out_valid | out_ready (combinational), occupancy max 1; all other requirements unchanged.

Structure
REQ-029 Shared package pipe_pkg SHALL hold the state enumeration (EMPTY, HALF, FULL) and the stall counter width constant STALL_CNT_W=16.
REQ-030 Sub-module pipe_stage_reg (DATA_W load/clear register with BUBBLE clear value) SHALL implement main and skid registers.

Verification
REQ-031 Reset, then in_valid=1, in_data=0x1234 with out_ready=1 -> out_valid=1, out_data=0x1234 next cycle; occupancy=1.
REQ-032 Streaming 0x1..0x8 back-to-back with out_ready=1 -> outputs 0x1..0x8 one per cycle, no bubbles, in_ready held 1.
REQ-033 (SKID_EN) out_ready=0 while sending 0xA, 0xB -> occupancy=2, in_ready=0, stall_cnt counts; release out_ready -> 0xA then 0xB in consecutive cycles.
REQ-034 FULL with 0xA/0xB, flush=1 with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0; 0xC never appears.
REQ-035 Hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF, no wrap; flush leaves it 0xFFFF; rst clears to 0.
REQ-036 Random in_valid/out_ready (seeded) 10000 cycles, both macro settings -> scoreboard order match, no loss or duplication.
